multicycle_main_controller: RTL and testbench

- Main control FSM for the multicycle RV32I datapath.
- Decodes the instruction opcode one state at a time and sequences every datapath enable.
- Drives ALUOp and the ALU input selects to the ALU controller, which turns ALUOp plus func3 into the 3-bit ALU operation.
- Also resolves branch outcomes from ALU flags.

---
 rtl/multicycle_main_controller.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_main_controller.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_controller.sv
// Main control FSM for the multicycle RV32I datapath (Moore outputs, Mealy PCWrite in BRANCH).
// Optional macro ILLEGAL_OPCODE_TRAP_EN: unknown opcodes trap into HALT and raise illegal.
module multicycle_main_controller #(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       zero,
  input  logic       neg,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic [1:0] ALUOp,
  output logic       illegal
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRLINK,
    S_LUI
`ifdef ILLEGAL_OPCODE_TRAP_EN
    , S_HALT
`endif
  } state_t;

  state_t state, state_nxt;
  logic   taken;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_nxt;
  end

  always_comb begin
    case (func3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = neg;
      3'b101:  taken = !neg;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ImmSrc    = 3'b000;
    RegWrite  = 1'b0;
    ALUOp     = 2'b00;
    illegal   = 1'b0;
    // Outputs stay all-zero while reset is held so no write leaks through.
    if (rst) begin
      case (state)
        S_FETCH: begin
          IRWrite   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          PCWrite   = 1'b1;
          state_nxt = S_DECODE;
        end
        S_DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
          case (opcode)
            OP_B:    ImmSrc = 3'b010;
            OP_JAL:  ImmSrc = 3'b011;
            OP_SW:   ImmSrc = 3'b001;
            OP_LUI:  ImmSrc = 3'b100;
            default: ImmSrc = 3'b000;
          endcase
          case (opcode)
            OP_LW, OP_SW: state_nxt = S_MEMADR;
            OP_R:         state_nxt = S_EXECR;
            OP_I:         state_nxt = S_EXECI;
            OP_B:         state_nxt = S_BRANCH;
            OP_JAL:       state_nxt = S_JAL;
            OP_JALR:      state_nxt = S_JALR;
            OP_LUI:       state_nxt = S_LUI;
`ifdef ILLEGAL_OPCODE_TRAP_EN
            default:      state_nxt = S_HALT;
`else
            default:      state_nxt = S_FETCH;
`endif
          endcase
        end
        S_MEMADR: begin
          ALUSrcA   = 2'b10;
          ALUSrcB   = 2'b01;
          ImmSrc    = (opcode == OP_SW) ? 3'b001 : 3'b000;
          state_nxt = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        end
        S_MEMREAD: begin
          AdrSrc    = 1'b1;
          state_nxt = S_MEMWB;
        end
        S_MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
          state_nxt = S_FETCH;
        end
        S_MEMWRITE: begin
          AdrSrc    = 1'b1;
          MemWrite  = 1'b1;
          state_nxt = S_FETCH;
        end
        S_EXECR: begin
          ALUSrcA   = 2'b10;
          ALUOp     = 2'b10;
          state_nxt = S_ALUWB;
        end
        S_EXECI: begin
          ALUSrcA   = 2'b10;
          ALUSrcB   = 2'b01;
          ALUOp     = 2'b10;
          state_nxt = S_ALUWB;
        end
        S_ALUWB: begin
          RegWrite  = 1'b1;
          state_nxt = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA   = 2'b10;
          ALUOp     = 2'b01;
          PCWrite   = taken;
          state_nxt = S_FETCH;
        end
        S_JAL: begin
          ALUSrcA   = 2'b01;
          ALUSrcB   = 2'b10;
          PCWrite   = 1'b1;
          state_nxt = S_ALUWB;
        end
        S_JALR: begin
          ALUSrcA   = 2'b10;
          ALUSrcB   = 2'b01;
          ResultSrc = 2'b10;
          PCWrite   = 1'b1;
          state_nxt = S_JALRLINK;
        end
        // Link value OldPC + 4 is formed after the jump target has been taken.
        S_JALRLINK: begin
          ALUSrcA   = 2'b01;
          ALUSrcB   = 2'b10;
          state_nxt = S_ALUWB;
        end
        S_LUI: begin
          ImmSrc    = 3'b100;
          ResultSrc = 2'b11;
          RegWrite  = 1'b1;
          state_nxt = S_FETCH;
        end
`ifdef ILLEGAL_OPCODE_TRAP_EN
        S_HALT: begin
          illegal   = 1'b1;
          state_nxt = S_HALT;
        end
`endif
        default: state_nxt = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Directed bench for multicycle_main_controller: per-cycle expected control words
// are queued by the stimulus and checked by a negedge monitor.
module tb_multicycle_main_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       zero, neg;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;

  multicycle_main_controller #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .zero(zero), .neg(neg),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .RegWrite(RegWrite), .ALUOp(ALUOp), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] v;
    string       n;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegWrite, ALUOp, illegal}
  function automatic logic [16:0] ev(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [2:0] imm, input logic rw,
                                     input logic [1:0] op, input logic ill);
    return {pcw, adr, mw, irw, rs, sa, sb, imm, rw, op, ill};
  endfunction

  wire [16:0] act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                     ImmSrc, RegWrite, ALUOp, illegal};

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (act !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %05h expected %05h", e.n, act, e.v);
      end
    end
  end

  task automatic cyc(input logic [16:0] v, input string n);
    exp_t e;
    e.v = v;
    e.n = n;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  logic [16:0] Z, FE, EXR, EXI, AWB, MRD, MWB, MWR, JALV, JALRV, LINK, LUIV, HALTV;

  function automatic logic [16:0] dec(input logic [2:0] imm);
    return ev(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 0, 2'b00, 0);
  endfunction
  function automatic logic [16:0] madr(input logic [2:0] imm);
    return ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, 0, 2'b00, 0);
  endfunction
  function automatic logic [16:0] br(input logic t);
    return ev(t, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 0, 2'b01, 0);
  endfunction

  task automatic branch(input logic [2:0] f3, input logic z, input logic n, input logic t,
                        input string nm);
    opcode = 7'b1100011;
    func3  = 3'b000;
    zero   = 1'b0;
    neg    = 1'b0;
    cyc(FE, {nm, "_fetch"});
    cyc(dec(3'b010), {nm, "_decode"});
    func3 = f3;
    zero  = z;
    neg   = n;
    cyc(br(t), nm);
  endtask

  initial begin
    Z     = '0;
    FE    = ev(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 0, 2'b00, 0);
    EXR   = ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 0, 2'b10, 0);
    EXI   = ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 2'b10, 0);
    AWB   = ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 2'b00, 0);
    MRD   = ev(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 2'b00, 0);
    MWB   = ev(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 1, 2'b00, 0);
    MWR   = ev(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 2'b00, 0);
    JALV  = ev(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0, 2'b00, 0);
    JALRV = ev(1, 0, 0, 0, 2'b10, 2'b10, 2'b01, 3'b000, 0, 2'b00, 0);
    LINK  = ev(0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0, 2'b00, 0);
    LUIV  = ev(0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 3'b100, 1, 2'b00, 0);
    HALTV = ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 2'b00, 1);

    rst = 1'b0; opcode = 7'b0110011; func3 = 3'b000; zero = 1'b0; neg = 1'b0;
    @(posedge clk);
    #1;
    cyc(Z, "reset0"); cyc(Z, "reset1"); cyc(Z, "reset2");
    rst = 1'b1;

    // R-type: 4 cycles, back in FETCH on the 5th
    cyc(FE, "r_fetch"); cyc(dec(3'b000), "r_decode"); cyc(EXR, "r_execr"); cyc(AWB, "r_aluwb");

    opcode = 7'b0010011;
    cyc(FE, "i_fetch"); cyc(dec(3'b000), "i_decode"); cyc(EXI, "i_execi"); cyc(AWB, "i_aluwb");

    opcode = 7'b0000011;
    cyc(FE, "lw_fetch"); cyc(dec(3'b000), "lw_decode"); cyc(madr(3'b000), "lw_memadr");
    cyc(MRD, "lw_memread"); cyc(MWB, "lw_memwb");

    opcode = 7'b0100011;
    cyc(FE, "sw_fetch"); cyc(dec(3'b001), "sw_decode"); cyc(madr(3'b001), "sw_memadr");
    cyc(MWR, "sw_memwrite");

    branch(3'b000, 1'b1, 1'b0, 1'b1, "beq_taken");
    branch(3'b000, 1'b0, 1'b0, 1'b0, "beq_not");
    branch(3'b001, 1'b1, 1'b0, 1'b0, "bne_not");
    branch(3'b001, 1'b0, 1'b0, 1'b1, "bne_taken");
    branch(3'b100, 1'b0, 1'b1, 1'b1, "blt_taken");
    branch(3'b101, 1'b0, 1'b1, 1'b0, "bge_not");
    branch(3'b101, 1'b1, 1'b0, 1'b1, "bge_taken");
    branch(3'b010, 1'b1, 1'b1, 1'b0, "f3_010");

    opcode = 7'b1101111;
    cyc(FE, "jal_fetch"); cyc(dec(3'b011), "jal_decode"); cyc(JALV, "jal_jal"); cyc(AWB, "jal_aluwb");

    opcode = 7'b1100111;
    cyc(FE, "jalr_fetch"); cyc(dec(3'b000), "jalr_decode"); cyc(JALRV, "jalr_jalr");
    cyc(LINK, "jalr_link"); cyc(AWB, "jalr_aluwb");

    opcode = 7'b0110111;
    cyc(FE, "lui_fetch"); cyc(dec(3'b100), "lui_decode"); cyc(LUIV, "lui_lui");

    // Reset lands just before MEMWRITE would have driven MemWrite
    opcode = 7'b0100011;
    cyc(FE, "abort_fetch"); cyc(dec(3'b001), "abort_decode"); cyc(madr(3'b001), "abort_memadr");
    rst = 1'b0;
    cyc(Z, "abort_rst0"); cyc(Z, "abort_rst1");
    rst = 1'b1;
    cyc(FE, "abort_refetch"); cyc(dec(3'b001), "abort_redecode");
    rst = 1'b0;
    cyc(Z, "abort_rst2");
    rst = 1'b1;

    opcode = 7'b1111111;
    cyc(FE, "ill_fetch"); cyc(dec(3'b000), "ill_decode");
`ifdef ILLEGAL_OPCODE_TRAP_EN
    cyc(HALTV, "ill_halt0"); cyc(HALTV, "ill_halt1"); cyc(HALTV, "ill_halt2");
    rst = 1'b0;
    cyc(Z, "ill_rst");
    rst = 1'b1;
    opcode = 7'b0110011;
    cyc(FE, "ill_recover");
`else
    cyc(FE, "ill_nop_fetch"); cyc(dec(3'b000), "ill_nop_decode"); cyc(FE, "ill_nop_fetch2");
`endif

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
